mult_dot_accumulator: RTL and testbench

//  Downstream consumer of pipelined_multiplier. Takes each completed product (done/result pulse).

---
 rtl/mult_pkg.sv | 32 +++
 rtl/mult_dot_accumulator.sv | 138 +++++++++++++
 tb/tb_mult_dot_accumulator.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the multiplier / dot-product accumulator slice.
// sat_add turns a one-bit-wider raw sum into a saturated value plus an overflow flag.
package mult_pkg;

  localparam int PROD_W_DEF = 16;

  // Widest accumulator sat_add supports; instantiating modules must keep ACC_W below this.
  localparam int SAT_MAX_W = 48;

  typedef enum logic {
    ACCUM = 1'b0,
    FULL  = 1'b1
  } state_t;

  typedef struct packed {
    logic                 ovf;
    logic [SAT_MAX_W-1:0] val;
  } sat_t;

  localparam logic [SAT_MAX_W:0] SAT_ONE = {{SAT_MAX_W{1'b0}}, 1'b1};

  // sum holds an (acc_w+1)-bit raw sum, zero-extended; bit acc_w is the carry.
  function automatic sat_t sat_add(input logic [SAT_MAX_W:0] sum, input int unsigned acc_w);
    sat_t                 r;
    logic [SAT_MAX_W-1:0] mask;
    mask  = SAT_MAX_W'((SAT_ONE << acc_w) - SAT_ONE);
    r.ovf = |((sum >> acc_w) & SAT_ONE);
    r.val = r.ovf ? mask : (sum[SAT_MAX_W-1:0] & mask);
    return r;
  endfunction

endpackage

// File: rtl/mult_dot_accumulator.sv
// Sums VEC_LEN consecutive products into a saturating dot product offered on valid/ready.
// One vector may be parked in the accumulator (FULL) while the output register waits.
module mult_dot_accumulator
  import mult_pkg::*;
#(
  parameter int PROD_W  = PROD_W_DEF,
  parameter int ACC_W   = 18,
  parameter int VEC_LEN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prod_vld,
  input  logic [PROD_W-1:0] prod,
  input  logic              clear,
  output logic [ACC_W-1:0]  sum_out,
  output logic              sum_ovf,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic              busy,
  output logic              drop,
  output state_t            state_dbg
);

  localparam int CNT_W = $clog2(VEC_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_LEN - 1);

  // Output handshake: a sum transfers on a cycle where sum_valid & sum_ready are both high;
  // sum_out/sum_ovf hold steady while sum_valid is high and sum_ready is low.

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               load_new;
  logic               load_park;
  logic               accept;
  logic               slot_free;
  logic [ACC_W:0]     add_sum;
  sat_t               sat_res;
  logic [ACC_W-1:0]   sat_val;
  logic               sat_ovf;
  logic               unused_sat_hi;

  assign add_sum       = {1'b0, acc_q} + (ACC_W + 1)'(prod);
  assign sat_res       = sat_add((SAT_MAX_W + 1)'(add_sum), ACC_W);
  assign sat_val       = sat_res.val[ACC_W-1:0];
  assign sat_ovf       = ovf_q | sat_res.ovf;
  // Bits above ACC_W are zero by construction of the saturation mask.
  assign unused_sat_hi = ^sat_res.val[SAT_MAX_W-1:ACC_W];

  assign accept    = sum_valid & sum_ready;
  assign slot_free = ~sum_valid | sum_ready;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    load_new  = 1'b0;
    load_park = 1'b0;
    drop      = 1'b0;
    if (clear) begin
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      state_d = ACCUM;
    end else begin
      case (state_q)
        ACCUM: begin
          if (prod_vld) begin
            if (cnt_q != CNT_LAST) begin
              acc_d = sat_val;
              ovf_d = sat_ovf;
              cnt_d = cnt_q + 1'b1;
            end else if (slot_free) begin
              load_new = 1'b1;
              acc_d    = '0;
              cnt_d    = '0;
              ovf_d    = 1'b0;
            end else begin
              // Completed sum waits in acc until the output register frees up.
              acc_d   = sat_val;
              ovf_d   = sat_ovf;
              state_d = FULL;
            end
          end
        end
        FULL: begin
          drop = prod_vld;
          if (accept) begin
            load_park = 1'b1;
            acc_d     = '0;
            cnt_d     = '0;
            ovf_d     = 1'b0;
            state_d   = ACCUM;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_out   <= '0;
      sum_ovf   <= 1'b0;
      sum_valid <= 1'b0;
    end else if (load_new) begin
      sum_out   <= sat_val;
      sum_ovf   <= sat_ovf;
      sum_valid <= 1'b1;
    end else if (load_park) begin
      sum_out   <= acc_q;
      sum_ovf   <= ovf_q;
      sum_valid <= 1'b1;
    end else if (accept) begin
      sum_valid <= 1'b0;
    end
  end

  assign busy      = (state_q == FULL) | (cnt_q != '0);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mult_dot_accumulator.sv
// Randomised plus directed bench for mult_dot_accumulator at ACC_W=18 and ACC_W=17.
// A sum-then-saturate reference model feeds per-instance expected queues checked by a monitor.
module tb_mult_dot_accumulator;
  import mult_pkg::*;

  localparam int VEC_LEN = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        prod_vld = 1'b0;
  logic [15:0] prod = '0;
  logic        clear = 1'b0;
  logic        sum_ready = 1'b0;

  logic [17:0] sum_out0;
  logic        sum_ovf0, sum_valid0, busy0, drop0;
  state_t      state0;
  logic [16:0] sum_out1;
  logic        sum_ovf1, sum_valid1, busy1, drop1;
  state_t      state1;

  mult_dot_accumulator #(.PROD_W(16), .ACC_W(18), .VEC_LEN(VEC_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .prod_vld(prod_vld), .prod(prod), .clear(clear),
    .sum_out(sum_out0), .sum_ovf(sum_ovf0), .sum_valid(sum_valid0), .sum_ready(sum_ready),
    .busy(busy0), .drop(drop0), .state_dbg(state0)
  );

  mult_dot_accumulator #(.PROD_W(16), .ACC_W(17), .VEC_LEN(VEC_LEN)) dut17 (
    .clk(clk), .rst_n(rst_n), .prod_vld(prod_vld), .prod(prod), .clear(clear),
    .sum_out(sum_out1), .sum_ovf(sum_ovf1), .sum_valid(sum_valid1), .sum_ready(sum_ready),
    .busy(busy1), .drop(drop1), .state_dbg(state1)
  );

  // ---------------- scoreboard / model state ----------------
  logic [18:0] exp_q0[$];
  logic [18:0] exp_q1[$];
  int          acc_w[2] = '{18, 17};
  int          pend[2];
  int          pcnt[2];
  longint      psum[2];
  logic        exp_valid[2];
  logic        exp_busy[2];
  logic        exp_drop[2];
  logic        exp_full[2];
  logic        chk_en = 1'b0;
  int          n_total = 0;
  int          n_pass = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  task automatic model_reset();
    exp_q0.delete();
    exp_q1.delete();
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0;
      pcnt[i] = 0;
      psum[i] = 0;
    end
  endtask

  // Reference: a vector's result is min(total, 2^W-1) with ovf = total > 2^W-1.
  // pend counts sums the DUT holds (output register plus at most one parked).
  task automatic model_step(input int i, input logic vld, input logic [15:0] p,
                            input logic clr, input logic rdy);
    logic        acc_now;
    longint      mx;
    logic [18:0] e;
    acc_now      = (pend[i] > 0) && rdy;
    exp_valid[i] = (pend[i] > 0);
    exp_busy[i]  = (pcnt[i] != 0) || (pend[i] == 2);
    exp_full[i]  = (pend[i] == 2);
    exp_drop[i]  = 1'b0;
    if (clr) begin
      pcnt[i] = 0;
      psum[i] = 0;
      if (pend[i] == 2) begin
        if (i == 0) void'(exp_q0.pop_back());
        else        void'(exp_q1.pop_back());
        pend[i] = 1;
      end
    end else if (vld) begin
      if (pend[i] == 2) begin
        exp_drop[i] = 1'b1;
      end else begin
        psum[i] += longint'(p);
        pcnt[i]++;
        if (pcnt[i] == VEC_LEN) begin
          mx = (longint'(1) << acc_w[i]) - 1;
          if (psum[i] > mx) e = {1'b1, 18'(mx)};
          else              e = {1'b0, 18'(psum[i])};
          if (i == 0) exp_q0.push_back(e);
          else        exp_q1.push_back(e);
          pend[i]++;
          pcnt[i] = 0;
          psum[i] = 0;
        end
      end
    end
    if (acc_now) pend[i]--;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_cycle(input logic vld, input logic [15:0] p, input logic clr, input logic rdy);
    @(posedge clk);
    #1;
    prod_vld  = vld;
    prod      = vld ? p : 16'($urandom);
    clear     = clr;
    sum_ready = rdy;
    chk_en    = 1'b1;
    model_step(0, vld, p, clr, rdy);
    model_step(1, vld, p, clr, rdy);
  endtask

  task automatic send_vec(input int a, input int b, input int c, input int d, input logic rdy);
    drive_cycle(1'b1, 16'(a), 1'b0, rdy);
    drive_cycle(1'b1, 16'(b), 1'b0, rdy);
    drive_cycle(1'b1, 16'(c), 1'b0, rdy);
    drive_cycle(1'b1, 16'(d), 1'b0, rdy);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int k = 0; k < n; k++) drive_cycle(1'b0, 16'd0, 1'b0, rdy);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sum0"}, sum_out0, 0);
    check({tag, "_ovf0"}, sum_ovf0, 0);
    check({tag, "_valid0"}, sum_valid0, 0);
    check({tag, "_busy0"}, busy0, 0);
    check({tag, "_drop0"}, drop0, 0);
    check({tag, "_sum1"}, sum_out1, 0);
    check({tag, "_valid1"}, sum_valid1, 0);
    check({tag, "_busy1"}, busy1, 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("valid0", sum_valid0, exp_valid[0]);
      check("busy0", busy0, exp_busy[0]);
      check("drop0", drop0, exp_drop[0]);
      check("full0", state0 == FULL, exp_full[0]);
      check("valid1", sum_valid1, exp_valid[1]);
      check("busy1", busy1, exp_busy[1]);
      check("drop1", drop1, exp_drop[1]);
      check("full1", state1 == FULL, exp_full[1]);
      if (sum_valid0 && sum_ready) begin
        if (exp_q0.size() == 0) begin
          n_total++;
          $display("FAIL sum0_unexpected: got %0d expected no output at %0t", sum_out0, $time);
        end else begin
          check("sum0", {sum_ovf0, sum_out0}, exp_q0.pop_front());
        end
      end
      if (sum_valid1 && sum_ready) begin
        if (exp_q1.size() == 0) begin
          n_total++;
          $display("FAIL sum1_unexpected: got %0d expected no output at %0t", sum_out1, $time);
        end else begin
          check("sum1", {sum_ovf1, 1'b0, sum_out1}, exp_q1.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    #3;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic vector, then back-to-back vectors with no bubble.
    send_vec(15, 24, 35, 48, 1'b1);
    idle(2, 1'b1);
    send_vec(1, 2, 3, 4, 1'b1);
    send_vec(10, 20, 30, 40, 1'b1);
    idle(2, 1'b1);

    // Backpressure: vec1 held, vec2 parked, vec3 dropped; then drain.
    send_vec(5, 6, 7, 8, 1'b0);
    send_vec(100, 200, 300, 400, 1'b0);
    send_vec(9, 9, 9, 9, 1'b0);
    idle(4, 1'b1);

    // Saturation on the 17-bit instance, then a clean vector.
    send_vec(65025, 65025, 65025, 65025, 1'b1);
    send_vec(1, 1, 1, 1, 1'b1);
    idle(2, 1'b1);

    // clear mid-vector, then clear while a sum is parked.
    drive_cycle(1'b1, 16'd100, 1'b0, 1'b1);
    drive_cycle(1'b1, 16'd200, 1'b0, 1'b1);
    drive_cycle(1'b1, 16'd7, 1'b1, 1'b1);
    send_vec(1, 2, 3, 4, 1'b1);
    idle(2, 1'b1);
    send_vec(11, 12, 13, 14, 1'b0);
    send_vec(21, 22, 23, 24, 1'b0);
    drive_cycle(1'b1, 16'd5, 1'b1, 1'b0);
    idle(2, 1'b1);
    send_vec(1, 2, 3, 4, 1'b1);
    idle(2, 1'b1);

    // Asynchronous reset mid-vector with a sum pending.
    send_vec(3, 3, 3, 3, 1'b0);
    drive_cycle(1'b1, 16'd50, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    prod_vld = 1'b0;
    chk_en   = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_vec(1, 1, 1, 1, 1'b1);
    idle(2, 1'b1);

    // Random traffic with backpressure, clears and large products.
    for (int c = 0; c < 2000; c++) begin
      logic        v, r, cl;
      logic [15:0] p;
      v  = ($urandom_range(0, 99) < 60);
      r  = ($urandom_range(0, 99) < 65);
      cl = ($urandom_range(0, 99) < 3);
      p  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(60000, 65535)) : 16'($urandom);
      drive_cycle(v, p, cl, r);
    end

    // Drain whatever is still held.
    idle(6, 1'b1);
    @(negedge clk);
    chk_en = 1'b0;
    check("drain_q0", exp_q0.size(), 0);
    check("drain_q1", exp_q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
